// File: rtl/max7219_serial_if.sv
// Shifts one 16-bit MAX7219 command word out on CLK/DIN, MSB first.
// An optional LOAD pulse follows, then a one-cycle done strobe.
module max7219_serial_if #(
   parameter int unsigned G_MAX_HALF_PERIOD = 4,
   parameter int unsigned G_LOAD_DURATION   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_en_load,
   input  logic [15:0] i_data,
   output logic        o_max7219_load,
   output logic        o_max7219_data,
   output logic        o_max7219_clk,
   output logic        o_done
);

   localparam int unsigned WORD_W = 16;
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned HP_W   = $clog2(G_MAX_HALF_PERIOD + 1);
   localparam int unsigned LD_W   = $clog2(G_LOAD_DURATION + 1);

   localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(G_MAX_HALF_PERIOD - 1);
   localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(G_LOAD_DURATION - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q,   state_d;
   logic [HP_W-1:0]     hp_cnt_q,  hp_cnt_d;
   logic [LD_W-1:0]     ld_cnt_q,  ld_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                phase_q,   phase_d;
   logic [WORD_W-1:0]   shreg_q,   shreg_d;
   logic                en_load_q, en_load_d;
   logic                load_q,    load_d;
   logic                data_q,    data_d;
   logic                sclk_q,    sclk_d;
   logic                done_q,    done_d;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hp_cnt_q  <= '0;
         ld_cnt_q  <= '0;
         bit_cnt_q <= '0;
         phase_q   <= 1'b0;
         shreg_q   <= '0;
         en_load_q <= 1'b0;
         load_q    <= 1'b0;
         data_q    <= 1'b0;
         sclk_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hp_cnt_q  <= hp_cnt_d;
         ld_cnt_q  <= ld_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         shreg_q   <= shreg_d;
         en_load_q <= en_load_d;
         load_q    <= load_d;
         data_q    <= data_d;
         sclk_q    <= sclk_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic; pin values are decoded from the next state so they leave flops
   always_comb begin
      state_d   = state_q;
      hp_cnt_d  = hp_cnt_q;
      ld_cnt_d  = ld_cnt_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      shreg_d   = shreg_q;
      en_load_d = en_load_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d   = SHIFT;
               shreg_d   = i_data;
               en_load_d = i_en_load;
               hp_cnt_d  = '0;
               bit_cnt_d = BIT_LAST;
               phase_d   = 1'b0;
            end
         end
         SHIFT: begin
            if (hp_cnt_q == HP_LAST) begin
               hp_cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else if (bit_cnt_q == '0) begin
                  state_d  = en_load_q ? LOAD : DONE;
                  ld_cnt_d = '0;
               end else begin
                  // Next bit is presented at the start of the following low phase
                  phase_d   = 1'b0;
                  bit_cnt_d = bit_cnt_q - BIT_W'(1);
                  shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
               end
            end else begin
               hp_cnt_d = hp_cnt_q + HP_W'(1);
            end
         end
         LOAD: begin
            if (ld_cnt_q == LD_LAST) begin
               state_d = DONE;
            end else begin
               ld_cnt_d = ld_cnt_q + LD_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sclk_d = (state_d == SHIFT) && phase_d;
      data_d = ((state_d == SHIFT) || (state_d == LOAD)) && shreg_d[WORD_W-1];
      load_d = (state_d == LOAD);
      done_d = (state_d == DONE);
   end

   assign o_max7219_load = load_q;
   assign o_max7219_data = data_q;
   assign o_max7219_clk  = sclk_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_max7219_serial_if.sv
// Scoreboard bench for max7219_serial_if: stimulus pushes expected frames,
// a pin monitor reassembles each frame and checks it when o_done appears.
`timescale 1ns/1ps
module tb_max7219_serial_if;

   localparam int H = 4;
   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_en_load = 1'b0;
   logic [15:0] i_data = '0;
   logic        o_max7219_load, o_max7219_data, o_max7219_clk, o_done;

   max7219_serial_if #(
      .G_MAX_HALF_PERIOD(H),
      .G_LOAD_DURATION  (L)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_en_load     (i_en_load),
      .i_data        (i_data),
      .o_max7219_load(o_max7219_load),
      .o_max7219_data(o_max7219_data),
      .o_max7219_clk (o_max7219_clk),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] w;
      bit          en;
      int          tn;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   next_free = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one transfer at the first edge the reference says the block is idle
   task automatic send(input logic [15:0] w, input bit en, input bit keep, output int tn);
      exp_t e;
      while (cyc + 1 < next_free) @(negedge clk);
      i_start   = 1'b1;
      i_data    = w;
      i_en_load = en;
      tn        = cyc + 1;
      e.w = w; e.en = en; e.tn = tn;
      sb.push_back(e);
      next_free = tn + 32 * H + (en ? L : 0) + 2;
      @(negedge clk);
      i_data    = 16'($urandom);
      i_en_load = 1'($urandom);
      if (!keep) i_start = 1'b0;
   endtask

   // Pin monitor
   int          nrise = 0, nload = 0, first_rise = -1, last_rise = -1, first_load = -1, bad_space = 0;
   logic [15:0] word_acc = '0;
   logic        prev_clk = 1'b0;

   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         nrise = 0; nload = 0; first_rise = -1; last_rise = -1; first_load = -1;
         bad_space = 0; word_acc = '0;
      end else begin
         if (o_max7219_clk && !prev_clk) begin
            if (nrise > 0 && (cyc - last_rise) != 2 * H) bad_space++;
            if (nrise == 0) first_rise = cyc;
            last_rise = cyc;
            word_acc  = {word_acc[14:0], o_max7219_data};
            nrise++;
         end
         if (o_max7219_load) begin
            if (nload == 0) begin
               first_load = cyc;
               chk("load_din_holds_bit0", 32'(o_max7219_data), 32'(word_acc[0]));
               chk("load_clk_low", 32'(o_max7219_clk), 32'd0);
            end
            nload++;
         end
         if (o_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.tn + 32 * H + (e.en ? L : 0)));
               chk("frame_word", 32'(word_acc), 32'(e.w));
               chk("clk_edges", 32'(nrise), 32'd16);
               chk("edge_spacing_errors", 32'(bad_space), 32'd0);
               chk("first_edge_cycle", 32'(first_rise), 32'(e.tn + H));
               chk("load_cycles", 32'(nload), 32'(e.en ? L : 0));
               if (e.en) chk("load_start_cycle", 32'(first_load), 32'(e.tn + 32 * H));
               chk("done_din_low", 32'(o_max7219_data), 32'd0);
            end
            nrise = 0; nload = 0; first_rise = -1; last_rise = -1; first_load = -1;
            bad_space = 0; word_acc = '0;
         end
      end
      prev_clk = o_max7219_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int tn;
      repeat (3) @(negedge clk);
      chk("reset_pins", 32'({o_max7219_load, o_max7219_data, o_max7219_clk, o_done}), 32'd0);
      rst = 1'b0;
      next_free = cyc + 1;
      repeat (20) begin
         @(negedge clk);
         chk("idle_pins", 32'({o_max7219_load, o_max7219_data, o_max7219_clk, o_done}), 32'd0);
      end

      send(16'h0C01, 1'b1, 1'b0, tn);
      send(16'hA5F0, 1'b0, 1'b0, tn);

      // Start pulse mid-transfer must be ignored
      send(16'h5A3C, 1'b1, 1'b0, tn);
      while (cyc < tn + 39) @(negedge clk);
      i_start = 1'b1; i_data = 16'hFFFF; i_en_load = 1'b0;
      @(negedge clk);
      i_start = 1'b0;

      // Reset mid-transfer abandons the frame
      send(16'h3C5A, 1'b1, 1'b0, tn);
      while (cyc < tn + 49) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      chk("post_reset_pins", 32'({o_max7219_load, o_max7219_data, o_max7219_clk, o_done}), 32'd0);
      rst = 1'b0;
      next_free = cyc + 1;
      send(16'h8001, 1'b1, 1'b0, tn);

      // Held-high start: back-to-back frames
      send(16'h0F00, 1'b1, 1'b1, tn);
      send(16'h0F01, 1'b1, 1'b0, tn);

      repeat (6) begin
         send(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, tn);
      end

      while (cyc < next_free + 4) @(negedge clk);
      chk("pending_frames", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
